// File: rtl/pipe_skid_seg.sv
// Pipeline segment register with valid/allowin handshake, flush, and an optional
// 2-entry skid buffer that keeps upstream allowin registered at full throughput.
module pipe_skid_seg #(
  parameter int DW         = 32,
  parameter int SKID       = 1,
  parameter int RESET_DATA = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_allowin,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_allowin,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  // Encoding doubles as the occupancy count
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_m_valid;
  logic [DW-1:0]   r_m_data;
  logic [DW-1:0]   w_s_data;
  logic            w_accept;
  logic            w_pop;
  logic            w_m_load_in;
  logic            w_m_load_s;
  logic            w_s_load;

  assign w_accept = in_valid && in_allowin;
  assign w_pop    = r_m_valid && out_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_EMPTY;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_m_valid <= (w_state_next != ST_EMPTY);
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_state_next = ST_ONE;
        ST_ONE: begin
          if (w_accept && !w_pop)
            w_state_next = (SKID != 0) ? ST_TWO : ST_ONE;
          else if (!w_accept && w_pop)
            w_state_next = ST_EMPTY;
        end
        ST_TWO:   if (w_pop) w_state_next = ST_ONE;
        default:  w_state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_m_load_in = 1'b0;
    w_m_load_s  = 1'b0;
    w_s_load    = 1'b0;
    case (r_state)
      ST_EMPTY: w_m_load_in = w_accept;
      ST_ONE: begin
        w_m_load_in = w_accept && w_pop;
        w_s_load    = w_accept && !w_pop && (SKID != 0);
      end
      ST_TWO:   w_m_load_s = w_pop;
      default: begin
        w_m_load_in = 1'b0;
      end
    endcase
  end

  generate
    if (RESET_DATA != 0) begin : g_m_rst
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)          r_m_data <= '0;
        else if (flush)       r_m_data <= '0;
        else if (w_m_load_in) r_m_data <= in_data;
        else if (w_m_load_s)  r_m_data <= w_s_data;
      end
    end else begin : g_m_hold
      always_ff @(posedge clk) begin
        if (!flush) begin
          if (w_m_load_in)     r_m_data <= in_data;
          else if (w_m_load_s) r_m_data <= w_s_data;
        end
      end
    end

    if (SKID != 0) begin : g_skid
      logic [DW-1:0] r_s_data;
      logic          r_allowin;

      if (RESET_DATA != 0) begin : g_s_rst
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn)       r_s_data <= '0;
          else if (flush)    r_s_data <= '0;
          else if (w_s_load) r_s_data <= in_data;
        end
      end else begin : g_s_hold
        always_ff @(posedge clk) begin
          if (!flush && w_s_load) r_s_data <= in_data;
        end
      end

      // Registered from the next state so upstream never sees out_allowin
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_allowin <= 1'b1;
        else         r_allowin <= (w_state_next != ST_TWO);
      end

      assign w_s_data   = r_s_data;
      assign in_allowin = r_allowin;
    end else begin : g_noskid
      assign w_s_data   = '0;
      assign in_allowin = !r_m_valid || out_allowin;
    end
  endgenerate

  assign out_valid = r_m_valid;
  assign out_data  = r_m_data;
  assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_skid_seg.sv
// Directed bench for pipe_skid_seg: a skid instance and a single-entry instance.
module tb_pipe_skid_seg;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_allowin;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_allowin;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  logic        in_valid0;
  logic        in_allowin0;
  logic [31:0] in_data0;
  logic        out_valid0;
  logic        out_allowin0;
  logic [31:0] out_data0;
  logic [1:0]  occupancy0;

  int total = 0;
  int bad   = 0;

  pipe_skid_seg #(.DW(32), .SKID(1), .RESET_DATA(1)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_data(in_data),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_skid_seg #(.DW(32), .SKID(0), .RESET_DATA(1)) dut0 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid0), .in_allowin(in_allowin0), .in_data(in_data0),
    .out_valid(out_valid0), .out_allowin(out_allowin0), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the skid instance's visible state in one go
  task automatic expect_state(input string tag, input logic v, input logic [31:0] d,
                              input logic [1:0] occ, input logic alw);
    check({tag, ".valid"}, 32'(v ? out_valid : out_valid), 32'(v));
    if (v) check({tag, ".data"}, out_data, d);
    check({tag, ".occ"}, 32'(occupancy), 32'(occ));
    check({tag, ".allowin"}, 32'(in_allowin), 32'(alw));
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_allowin = 1'b0;
    in_valid0 = 1'b0; in_data0 = '0; out_allowin0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    expect_state("post_reset", 1'b0, 32'h0, 2'd0, 1'b1);

    // Reset while holding a beat clears outputs before any clock edge
    in_valid = 1'b1; in_data = 32'hA5A5A5A5;
    tick();
    in_valid = 1'b0;
    expect_state("hold_a5", 1'b1, 32'hA5A5A5A5, 2'd1, 1'b1);
    resetn = 1'b0;
    #1;
    check("async_rst.valid", 32'(out_valid), 32'd0);
    check("async_rst.data", out_data, 32'h0);
    check("async_rst.occ", 32'(occupancy), 32'd0);
    check("async_rst.allowin", 32'(in_allowin), 32'd1);
    resetn = 1'b1;
    tick();
    expect_state("after_release", 1'b0, 32'h0, 2'd0, 1'b1);

    // Streaming at full throughput
    out_allowin = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      expect_state($sformatf("stream%0d", i), 1'b1, 32'(i), 2'd1, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    expect_state("stream_end", 1'b0, 32'h0, 2'd0, 1'b1);

    // Backpressure fills the skid entry; the third beat is re-presented
    out_allowin = 1'b0;
    in_valid = 1'b1; in_data = 32'h10;
    tick();
    expect_state("bp_one", 1'b1, 32'h10, 2'd1, 1'b1);
    in_data = 32'h11;
    tick();
    expect_state("bp_two", 1'b1, 32'h10, 2'd2, 1'b0);
    in_data = 32'h12;
    tick();
    expect_state("bp_stall", 1'b1, 32'h10, 2'd2, 1'b0);
    out_allowin = 1'b1;
    tick();
    expect_state("bp_pop1", 1'b1, 32'h11, 2'd1, 1'b1);
    tick();
    expect_state("bp_pop2", 1'b1, 32'h12, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();
    expect_state("bp_drained", 1'b0, 32'h0, 2'd0, 1'b1);

    // Skid drain: one pop from TWO promotes S to M
    out_allowin = 1'b0;
    in_valid = 1'b1; in_data = 32'h20;
    tick();
    in_data = 32'h21;
    tick();
    expect_state("drain_two", 1'b1, 32'h20, 2'd2, 1'b0);
    in_valid = 1'b0; out_allowin = 1'b1;
    tick();
    expect_state("drain_pop", 1'b1, 32'h21, 2'd1, 1'b1);
    tick();
    expect_state("drain_empty", 1'b0, 32'h0, 2'd0, 1'b1);

    // Flush from TWO with a beat offered
    out_allowin = 1'b0;
    in_valid = 1'b1; in_data = 32'h30;
    tick();
    in_data = 32'h31;
    tick();
    expect_state("flush_two", 1'b1, 32'h30, 2'd2, 1'b0);
    in_data = 32'h32; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    expect_state("flush_done", 1'b0, 32'h0, 2'd0, 1'b1);
    check("flush_done.data_cleared", out_data, 32'h0);
    out_allowin = 1'b1;
    tick();
    check("flush_no32.valid", 32'(out_valid), 32'd0);

    // Beat accepted in the flush cycle is discarded
    out_allowin = 1'b0;
    in_valid = 1'b1; in_data = 32'h40;
    tick();
    in_data = 32'h41; flush = 1'b1;
    #1;
    check("flush_accept.allowin", 32'(in_allowin), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    expect_state("flush_accept_done", 1'b0, 32'h0, 2'd0, 1'b1);
    check("flush_accept.data", out_data, 32'h0);

    // Single-entry variant: combinational allowin
    in_valid0 = 1'b1; in_data0 = 32'h50; out_allowin0 = 1'b0;
    #1;
    check("s0_empty.allowin", 32'(in_allowin0), 32'd1);
    tick();
    in_data0 = 32'h51;
    check("s0_full.valid", 32'(out_valid0), 32'd1);
    check("s0_full.data", out_data0, 32'h50);
    check("s0_full.allowin", 32'(in_allowin0), 32'd0);
    tick();
    check("s0_stall.data", out_data0, 32'h50);
    out_allowin0 = 1'b1;
    #1;
    check("s0_raise.allowin", 32'(in_allowin0), 32'd1);
    tick();
    in_valid0 = 1'b0;
    check("s0_swap.data", out_data0, 32'h51);
    check("s0_swap.occ", 32'(occupancy0), 32'd1);
    tick();
    check("s0_empty.valid", 32'(out_valid0), 32'd0);
    check("s0_empty.occ", 32'(occupancy0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_seg.md
Name: pipe_skid_seg

Overview:
- Generalised pipeline segment register for inter-stage boundaries (ID/EX, EX/MEM, MEM/WB); replaces fixed field-by-field stage registers with one DW-bit payload bus.
- Adds a valid/allowin handshake, backpressure, synchronous flush and an optional 2-entry skid buffer, so upstream allowin is fully registered at full throughput.
- Stage wrappers pack their fields (pc, inst, res, regwen, wreg, ...) into in_data and unpack them from out_data.

Parameters:
- DW, 32, payload width in bits (1..1024).
- SKID, 1: 1 = 2-entry skid buffer, in_allowin registered. 0 = single entry, in_allowin combinational.
- RESET_DATA, 1: 1 = payload registers cleared to 0 on reset and flush. 0 = payload holds on reset/flush; only valid bits clear.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held beats (exception/branch redirect).
- in_valid  in  1  upstream beat present.
- in_allowin  out  1  segment can accept a beat this cycle.
- in_data  in  DW  upstream payload.
- out_valid  out  1  head beat present, driven directly from a register.
- out_allowin  in  1  downstream accepts the head beat this cycle.
- out_data  out  DW  head payload, driven directly from a register.
- occupancy  out  2  number of held beats (0..2); always 0..1 when SKID=0.

Behaviour:
- Handshake rules:
  - Accept when in_valid && in_allowin.
  - Pop when out_valid && out_allowin.
  - in_data is sampled only on accept.
  - out_data must stay stable while out_valid && !out_allowin.
- Storage: main entry (M) drives the outputs; skid entry (S) exists only when SKID=1.
- State machine, SKID=1 (states EMPTY, ONE, TWO; occupancy = 0, 1, 2):
  - EMPTY: accept -> ONE (M <= in_data).
  - ONE, accept && pop -> ONE (M <= in_data).
  - ONE, accept && !pop -> TWO (S <= in_data).
  - ONE, !accept && pop -> EMPTY.
  - TWO, pop -> ONE (M <= S). No accept is possible in TWO.
  - TWO, !pop -> TWO, contents held.
  - in_allowin = (state != TWO), from a register. It has no combinational path from out_allowin.
- SKID=0:
  - in_allowin = !M_valid || out_allowin.
  - accept -> M <= in_data, M_valid=1.
  - pop without accept -> M_valid=0.
- Ordering: beats leave in acceptance order; no beat is duplicated or dropped except by flush.
- Latency: an accepted beat is visible on out_valid/out_data in the next cycle when the segment was empty (or popping in ONE). Minimum latency is 1 cycle.
- Flush (synchronous, highest priority after reset):
  - Next state is EMPTY, occupancy 0.
  - A beat accepted in the flush cycle is discarded; upstream still treats it as consumed.
  - in_allowin in the flush cycle follows the normal rule.
  - out_valid in the flush cycle is unaffected, because it is a register. A pop in that same cycle still completes.
  - With RESET_DATA=1, M and S payloads are cleared to 0.
- Asynchronous reset (resetn=0):
  - Immediately: out_valid=0, occupancy=0, in_allowin=1.
  - out_data = 0 if RESET_DATA=1, else undefined/held.
  - Mid-operation reset discards all held beats.
  - Deassertion is taken as synchronised externally.
- No overflow is possible: in TWO, in_allowin=0.
- Beats presented while in_allowin=0 are ignored.

Test Plan:
- Reset/basic: resetn=0 mid-stream holding 0xA5A5A5A5 -> out_valid=0 and out_data=0 immediately, before any edge. After release, in_allowin=1 and occupancy=0.
- Streaming: out_allowin=1, feed 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the three following cycles, occupancy stays 1, in_allowin stays 1.
- Backpressure (SKID=1): feed 0x10,0x11,0x12 with out_allowin=0 -> occupancy reaches 2 and in_allowin=0. 0x12 is not accepted and is re-presented. Raise out_allowin -> output order 0x10,0x11,0x12.
- Skid drain: in TWO holding 0x20/0x21, pop once -> next cycle out_data=0x21, occupancy=1, in_allowin=1.
- Flush: occupancy=2 with 0x30/0x31, flush=1 while in_valid=1 with 0x32 -> next cycle out_valid=0, occupancy=0, and 0x32 never appears on out_data.
- SKID=0 variant: M full, out_allowin=0 -> in_allowin=0 the same cycle. Raise out_allowin -> in_allowin=1 combinationally, and accept plus pop complete in one cycle.
